// File: rtl/combo_pkg.sv
// ---------------------------------------------------------------------------
// combo_pkg
//  Shared definitions for the combo_pipe unit.
//  - choice_t : operation selector carried on the 'choice' port
//               (mux, priority encoder, binary decoder, illegal).
//  - is_legal : helper telling whether a selection counts as a real op.
// ---------------------------------------------------------------------------
package combo_pkg;

   typedef enum logic [1:0] {
      CH_MUX = 2'b00,
      CH_ENC = 2'b01,
      CH_DEC = 2'b10,
      CH_ILL = 2'b11
   } choice_t;

   // Only the illegal code is excluded from the operation count, so a
   // single helper keeps that rule in one place.
   function automatic logic is_legal(input choice_t ch);
      return (ch != CH_ILL);
   endfunction

endpackage : combo_pkg

// File: rtl/combo_pipe_prio_encoder.sv
// ---------------------------------------------------------------------------
// prio_encoder
//  Combinational highest-set-bit encoder.
//  Ports:
//    req   in   2**ENC_W  request vector
//    idx   out  ENC_W     index of the highest set bit (0 when req==0)
//    valid out  1         at least one request bit is set
// ---------------------------------------------------------------------------
module prio_encoder #(
   parameter int ENC_W = 2
) (
   input  logic [2**ENC_W-1:0] req,
   output logic [ENC_W-1:0]    idx,
   output logic                valid
);

   localparam int N_REQ = 2**ENC_W;

   // Scan from bit 0 upward and let every later hit overwrite the earlier
   // one, so the highest set bit is what remains at the end of the loop.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) begin
            idx   = ENC_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule : prio_encoder

// File: rtl/combo_pipe.sv
// ---------------------------------------------------------------------------
// combo_pipe
//  Registered mux / priority-encoder / decoder unit behind a valid/ready
//  handshake. One request is accepted per cycle when the single-entry
//  output register is empty or being drained; the result appears one cycle
//  after acceptance and is held while the consumer stalls.
//  Ports:
//    clk, rst_n         clock (rising edge), async active-low reset
//    in_valid/in_ready  request handshake (in_ready is combinational)
//    choice             00 mux, 01 encoder, 10 decoder, 11 illegal
//    sel, mux_in        mux select and data
//    enc_in             encoder request vector
//    dec_in             decoder binary input
//    cnt_clr            synchronous clear of op_count
//    out_valid/out_ready result handshake
//    mux_out, enc_out, enc_valid, dec_out, err_illegal   registered beat
//    op_count           saturating count of accepted legal operations
// ---------------------------------------------------------------------------
module combo_pipe
   import combo_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int ENC_W = 2,
   parameter int DEC_W = 2,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          choice,
   input  logic [SEL_W-1:0]    sel,
   input  logic [2**SEL_W-1:0] mux_in,
   input  logic [2**ENC_W-1:0] enc_in,
   input  logic [DEC_W-1:0]    dec_in,
   input  logic                cnt_clr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                mux_out,
   output logic [ENC_W-1:0]    enc_out,
   output logic                enc_valid,
   output logic [2**DEC_W-1:0] dec_out,
   output logic                err_illegal,
   output logic [CNT_W-1:0]    op_count
);

   localparam int N_DEC = 2**DEC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   choice_t          ch;
   logic             accept;
   logic             legal_accept;
   logic [ENC_W-1:0] enc_idx;
   logic             enc_hit;

   logic             nxt_mux;
   logic [ENC_W-1:0] nxt_enc;
   logic             nxt_enc_valid;
   logic [N_DEC-1:0] nxt_dec;
   logic             nxt_err;

   assign ch = choice_t'(choice);

   // in_ready is held low while reset is asserted so the unit reports no
   // capacity until it is actually able to register a request.
   assign in_ready     = rst_n & (~out_valid | out_ready);
   assign accept       = in_valid & in_ready;
   assign legal_accept = accept & is_legal(ch);

   prio_encoder #(
      .ENC_W (ENC_W)
   ) u_prio_encoder (
      .req   (enc_in),
      .idx   (enc_idx),
      .valid (enc_hit)
   );

   // Build the next beat: only the field belonging to the selected
   // operation carries data, every other field of the beat is zero.
   always_comb begin
      nxt_mux       = 1'b0;
      nxt_enc       = '0;
      nxt_enc_valid = 1'b0;
      nxt_dec       = '0;
      nxt_err       = 1'b0;
      case (ch)
         CH_MUX: nxt_mux = mux_in[sel];
         CH_ENC: begin
            nxt_enc       = enc_idx;
            nxt_enc_valid = enc_hit;
         end
         CH_DEC: nxt_dec = N_DEC'(1) << dec_in;
         CH_ILL: nxt_err = 1'b1;
      endcase
   end

   // Single-entry output register. A new beat loads whenever a request is
   // accepted, which also covers the drain-and-refill case with no bubble.
   // Draining without a new request only drops out_valid; the data fields
   // keep their old contents since nobody looks at them then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         mux_out     <= 1'b0;
         enc_out     <= '0;
         enc_valid   <= 1'b0;
         dec_out     <= '0;
         err_illegal <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         mux_out     <= nxt_mux;
         enc_out     <= nxt_enc;
         enc_valid   <= nxt_enc_valid;
         dec_out     <= nxt_dec;
         err_illegal <= nxt_err;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

   // Operation counter. A clear wins over the increment but still counts a
   // legal request accepted in the same cycle, so it restarts at 1 then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (cnt_clr) begin
         op_count <= legal_accept ? CNT_W'(1) : '0;
      end else if (legal_accept && (op_count != CNT_MAX)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule : combo_pipe

// File: tb/tb_combo_pipe.sv
// ---------------------------------------------------------------------------
// tb_combo_pipe
//  Self-checking bench for combo_pipe (SEL_W=ENC_W=DEC_W=2, CNT_W=2 so the
//  counter saturates quickly). A behavioural model tracks the expected
//  output register and operation count; directed scenarios are followed by
//  a randomized run.
// ---------------------------------------------------------------------------
module tb_combo_pipe;

   localparam int SEL_W   = 2;
   localparam int ENC_W   = 2;
   localparam int DEC_W   = 2;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       choice;
   logic [SEL_W-1:0] sel;
   logic [3:0]       mux_in;
   logic [3:0]       enc_in;
   logic [DEC_W-1:0] dec_in;
   logic             cnt_clr;
   logic             out_valid;
   logic             out_ready;
   logic             mux_out;
   logic [ENC_W-1:0] enc_out;
   logic             enc_valid;
   logic [3:0]       dec_out;
   logic             err_illegal;
   logic [CNT_W-1:0] op_count;

   int vectors;
   int miscompares;

   // Model of the output register and counter.
   logic       m_valid;
   logic       m_mux;
   int         m_enc;
   logic       m_encv;
   int         m_dec;
   logic       m_err;
   int         m_cnt;

   combo_pipe #(
      .SEL_W (SEL_W),
      .ENC_W (ENC_W),
      .DEC_W (DEC_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .choice      (choice),
      .sel         (sel),
      .mux_in      (mux_in),
      .enc_in      (enc_in),
      .dec_in      (dec_in),
      .cnt_clr     (cnt_clr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .mux_out     (mux_out),
      .enc_out     (enc_out),
      .enc_valid   (enc_valid),
      .dec_out     (dec_out),
      .err_illegal (err_illegal),
      .op_count    (op_count)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_valid = 1'b0;
      m_mux   = 1'b0;
      m_enc   = 0;
      m_encv  = 1'b0;
      m_dec   = 0;
      m_err   = 1'b0;
      m_cnt   = 0;
   endtask

   // Drives one cycle of inputs, checks in_ready before the edge, advances
   // the model on the edge and checks the registered outputs after it.
   task automatic applyStimulus(input string tag, input logic vld,
                                input logic [1:0] ch, input logic [1:0] s,
                                input logic [3:0] mi, input logic [3:0] ei,
                                input logic [1:0] di, input logic clr,
                                input logic ordy);
      logic acc;
      logic b_mux;
      int   b_enc;
      logic b_encv;
      int   b_dec;
      logic b_err;
      @(negedge clk);
      in_valid  = vld;
      choice    = ch;
      sel       = s;
      mux_in    = mi;
      enc_in    = ei;
      dec_in    = di;
      cnt_clr   = clr;
      out_ready = ordy;
      #1;
      checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
      acc = vld && (!m_valid || ordy);

      b_mux  = 1'b0;
      b_enc  = 0;
      b_encv = 1'b0;
      b_dec  = 0;
      b_err  = 1'b0;
      case (ch)
         2'd0: b_mux = ((mi >> s) & 4'd1) != 0;
         2'd1: begin
            for (int i = 3; i >= 0; i--) begin
               if (!b_encv && ((ei >> i) & 4'd1) != 0) begin
                  b_enc  = i;
                  b_encv = 1'b1;
               end
            end
         end
         2'd2: b_dec = 1 << di;
         default: b_err = 1'b1;
      endcase

      @(posedge clk);
      if (acc) begin
         m_valid = 1'b1;
         m_mux   = b_mux;
         m_enc   = b_enc;
         m_encv  = b_encv;
         m_dec   = b_dec;
         m_err   = b_err;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      if (clr)
         m_cnt = (acc && ch != 2'd3) ? 1 : 0;
      else if (acc && ch != 2'd3 && m_cnt < CNT_MAX)
         m_cnt = m_cnt + 1;

      #1;
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      checkOutput({tag, ".op_count"}, 32'(op_count), 32'(m_cnt));
      if (m_valid) begin
         checkOutput({tag, ".mux_out"}, 32'(mux_out), 32'(m_mux));
         checkOutput({tag, ".enc_out"}, 32'(enc_out), 32'(m_enc));
         checkOutput({tag, ".enc_valid"}, 32'(enc_valid), 32'(m_encv));
         checkOutput({tag, ".dec_out"}, 32'(dec_out), 32'(m_dec));
         checkOutput({tag, ".err_illegal"}, 32'(err_illegal), 32'(m_err));
      end
   endtask

   // Checks that every output reads zero while reset is held.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, ".mux_out"}, 32'(mux_out), 32'd0);
      checkOutput({tag, ".enc_out"}, 32'(enc_out), 32'd0);
      checkOutput({tag, ".enc_valid"}, 32'(enc_valid), 32'd0);
      checkOutput({tag, ".dec_out"}, 32'(dec_out), 32'd0);
      checkOutput({tag, ".err_illegal"}, 32'(err_illegal), 32'd0);
      checkOutput({tag, ".op_count"}, 32'(op_count), 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      choice      = 2'd0;
      sel         = '0;
      mux_in      = '0;
      enc_in      = '0;
      dec_in      = '0;
      cnt_clr     = 1'b0;
      out_ready   = 1'b0;
      modelReset();

      // Power-on reset state.
      #2;
      checkAllZero("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Mux: mux_in=0100, sel=2 selects the set bit.
      applyStimulus("mux", 1, 2'd0, 2'd2, 4'b0100, 4'b1111, 2'd3, 0, 1);
      // Encoder with bits 1 and 2 set, then with no bits set.
      applyStimulus("enc", 1, 2'd1, 2'd0, 4'b1111, 4'b0110, 2'd3, 0, 1);
      applyStimulus("enc0", 1, 2'd1, 2'd0, 4'b1111, 4'b0000, 2'd3, 0, 1);
      // Decoder and illegal selection.
      applyStimulus("dec", 1, 2'd2, 2'd3, 4'b1111, 4'b1111, 2'd3, 0, 1);
      applyStimulus("ill", 1, 2'd3, 2'd3, 4'b1111, 4'b1111, 2'd3, 0, 1);
      applyStimulus("drain", 0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 1);

      // Backpressure: beat held for three stalled cycles, then a refill
      // together with the drain.
      applyStimulus("bp.load", 1, 2'd2, 2'd0, 4'b0000, 4'b0000, 2'd1, 0, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus("bp.stall", 1, 2'd0, 2'd1, 4'b0010, 4'b0000, 2'd0, 0, 0);
      applyStimulus("bp.refill", 1, 2'd1, 2'd0, 4'b0000, 4'b1000, 2'd0, 0, 1);
      applyStimulus("bp.next", 1, 2'd0, 2'd3, 4'b1000, 4'b0000, 2'd0, 0, 1);

      // Counter: clear, five legal accepts saturate, then clear with accept.
      applyStimulus("cnt.clr", 0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1, 1);
      for (int i = 0; i < 5; i++)
         applyStimulus("cnt.inc", 1, 2'(i % 3), 2'd1, 4'b0010, 4'b0001, 2'd1, 0, 1);
      checkOutput("cnt.sat", 32'(op_count), 32'(CNT_MAX));
      applyStimulus("cnt.clracc", 1, 2'd0, 2'd1, 4'b0010, 4'b0000, 2'd0, 1, 1);

      // Reset while a beat is pending: outputs clear at once, nothing after.
      applyStimulus("rst.load", 1, 2'd2, 2'd0, 4'b0000, 4'b0000, 2'd2, 0, 0);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("rst.mid");
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("rst.after", 0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      applyStimulus("rst.after2", 0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 1);

      // Randomized traffic with random stalls and occasional clears.
      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand",
                       $urandom_range(0, 3) != 0,
                       2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)),
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 4) < 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_combo_pipe
